// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 widths, key-schedule FSM encoding and round constants.
package aes_pkg;
  localparam int KEY_W = 128;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
endpackage

// File: rtl/inv_key_schedule_if.sv
// inv_key_schedule_if: load request and round-key stream of the inverse key schedule.
interface inv_key_schedule_if;
  import aes_pkg::*;
  logic [KEY_W-1:0] key_in;
  logic key_is_last;
  logic start;
  logic busy;
  logic [KEY_W-1:0] rk_out;
  logic [3:0] rk_round;
  logic rk_valid;
  logic rk_ready;
  logic done;
  modport master(output key_in, key_is_last, start, rk_ready,
                 input busy, rk_out, rk_round, rk_valid, done);
  modport slave(input key_in, key_is_last, start, rk_ready,
                output busy, rk_out, rk_round, rk_valid, done);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: AES S-box on four bytes, computed as GF(2^8) inverse plus affine map.
module aes_sbox (
  input  logic [31:0] word,
  output logic [31:0] sub
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xt(x);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t, y;
    t = gmul(x, x);
    y = t;
    for (int i = 0; i < 6; i++) begin
      t = gmul(t, t);
      y = gmul(y, t);
    end
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign sub[8*b +: 8] = sbox(word[8*b +: 8]);
  end
endmodule

// File: rtl/inv_ks_step.sv
// inv_ks_step: one AES-128 key-schedule step, forward (round-1 -> round) or inverse (round -> round-1).
module inv_ks_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic [3:0]       round,
  input  logic             inv,
  output logic [KEY_W-1:0] next
);
  logic [WORD_W-1:0] k0, k1, k2, k3, sin, sub, n0;
  assign {k0, k1, k2, k3} = key;
  // inverse recovers the previous word 3 first, then feeds it through the same g() as forward
  assign sin = inv ? k3 ^ k2 : k3;
  aes_sbox u_sbox (.word({sin[23:0], sin[31:24]}), .sub(sub));
  assign n0 = k0 ^ sub ^ {RCON[round], 24'h0};
  assign next = inv ? {n0, k1 ^ k0, k2 ^ k1, k3 ^ k2}
                    : {n0, k1 ^ n0, k2 ^ k1 ^ n0, k3 ^ k2 ^ k1 ^ n0};
endmodule

// File: rtl/inv_key_schedule.sv
// inv_key_schedule: streams AES-128 round keys 10 down to 0, from either the cipher key or the last round key.
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input logic clk,
  input logic rst_n,
  inv_key_schedule_if.slave bus
);
  state_t state, state_nxt;
  logic [3:0] round;
  logic [KEY_W-1:0] key, key_nxt;
  logic emit, xfer, done_r;
  assign emit = state == EMIT;
  assign xfer = emit & bus.rk_ready;
  inv_ks_step u_step (.key(key), .round(emit ? round : round + 4'd1), .inv(emit), .next(key_nxt));
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (bus.start ? (bus.key_is_last ? EMIT : FWD) : IDLE)
              : state == FWD  ? (round == 4'(NR - 1) ? EMIT : FWD)
              : (xfer && round == 4'd0 ? IDLE : EMIT);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key <= '0;
      round <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= xfer && round == 4'd0;
      if (state == IDLE && bus.start) begin
        key <= bus.key_in;
        round <= bus.key_is_last ? 4'(NR) : 4'd0;
      end else if (state == FWD || (xfer && round != 4'd0)) begin
        key <= key_nxt;
        round <= emit ? round - 4'd1 : round + 4'd1;
      end
    end
  assign bus.busy = state != IDLE;
  assign bus.rk_valid = emit;
  assign bus.rk_out = key;
  assign bus.rk_round = round;
  assign bus.done = done_r;
endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule: directed runs of the FIPS-197 key expansion through the inverse key schedule.
module tb_inv_key_schedule;
  typedef struct {
    logic         last;
    logic [127:0] key;
    int           lat;
    bit           stall;
  } run_t;
  logic clk, rst_n;
  int errors, checks;
  run_t runs[4];
  logic [127:0] rk_exp[11];
  inv_key_schedule_if bus ();
  inv_key_schedule #(.NR(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_zero();
    chk("reset busy", bus.busy, 0);
    chk("reset rk_valid", bus.rk_valid, 0);
    chk("reset done", bus.done, 0);
    chk("reset rk_out", bus.rk_out, 0);
    chk("reset rk_round", bus.rk_round, 0);
  endtask
  // called at a negedge; start is sampled on the following posedge
  task automatic run_seq(input run_t r);
    int lat, st;
    bus.key_in = r.key;
    bus.key_is_last = r.last;
    bus.start = 1'b1;
    bus.rk_ready = r.stall;
    @(negedge clk);
    chk("done low after start", bus.done, 0);
    chk("busy after start", bus.busy, 1);
    lat = 1;
    bus.start = r.stall;
    if (r.stall) bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    while (!bus.rk_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk("first valid latency", lat, r.lat);
    for (int k = 10; k >= 0; k--) begin
      chk("rk_valid", bus.rk_valid, 1);
      chk("rk_round", bus.rk_round, k);
      chk("rk_out", bus.rk_out, rk_exp[k]);
      st = r.stall ? $urandom_range(0, 3) : 0;
      repeat (st) begin
        bus.rk_ready = 1'b0;
        bus.start = 1'b1;
        bus.key_is_last = $urandom_range(0, 1);
        bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        chk("stall rk_round", bus.rk_round, k);
        chk("stall rk_out", bus.rk_out, rk_exp[k]);
        chk("stall rk_valid", bus.rk_valid, 1);
      end
      bus.start = 1'b0;
      bus.rk_ready = 1'b1;
      @(negedge clk);
    end
    chk("done pulse", bus.done, 1);
    chk("rk_valid low after round 0", bus.rk_valid, 0);
    chk("idle after round 0", bus.busy, 0);
    bus.rk_ready = 1'b0;
  endtask
  initial begin
    int cnt;
    rk_exp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_exp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_exp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_exp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_exp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_exp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_exp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_exp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_exp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_exp[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_exp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    runs[0] = '{1'b0, rk_exp[0], 11, 1'b0};
    runs[1] = '{1'b1, rk_exp[10], 1, 1'b0};
    runs[2] = '{1'b0, rk_exp[0], 11, 1'b1};
    runs[3] = '{1'b1, rk_exp[10], 1, 1'b1};
    errors = 0;
    checks = 0;
    clk = 1'b0;
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.key_is_last = 1'b0;
    bus.rk_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_seq(runs[i]);
    @(negedge clk);
    chk("done single pulse", bus.done, 0);
    bus.key_in = rk_exp[10];
    bus.key_is_last = 1'b1;
    bus.start = 1'b1;
    bus.rk_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (bus.rk_round != 4'd5 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach round 5", bus.rk_round, 5);
    chk("round 5 key", bus.rk_out, rk_exp[5]);
    rst_n = 1'b0;
    #1 chk_zero();
    @(negedge clk);
    rst_n = 1'b1;
    bus.rk_ready = 1'b0;
    run_seq(runs[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
